serial_alu_core: RTL and testbench
==================================

Name: serial_alu_core

Overview:
- Parametrised successor to the fixed 8-bit serial-programmed processor.
- A 5-state serial control FSM is driven by mode input x. It scans IW-bit instructions in LSB-first and executes each exactly once after update, on a 2**REG_ADDR_W x DATA_W register file.
- Results are written back and presented on z.
- Entering shift captures the last result into the shift register, so results can be read back serially.

Parameters:
DATA_W, 4, register/operand width (>=2)
REG_ADDR_W, 2, register address width; NREGS = 2**REG_ADDR_W
IW (localparam), 3 + max(DATA_W+REG_ADDR_W, 3*REG_ADDR_W), instruction width; 9 at defaults

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
x  in  1  mode/steer input sampled by FSM each posedge
data_in  in  1  serial instruction bit, used in SHIFT
data_out  out  1  registered serial output, LSB first
z  out  DATA_W+1  last result; MSB = carry/borrow
zero  out  1  z[DATA_W-1:0]==0, registered with z
done  out  1  one-cycle pulse after an instruction executes

Behaviour:
- Reset (rst_n=0, async): state=RESET; shift_reg, shadow_reg, all registers, z, zero, data_out and done all clear to 0 immediately.
- FSM states and next-state rules:
  - RESET: x ? RESET : IDLE. While in RESET, the register file, shadow_reg and z are cleared synchronously.
  - IDLE: x ? SHIFT : IDLE.
  - SHIFT: x ? SHIFT : UPDATE.
  - UPDATE: always goes to EXEC.
  - EXEC: x ? RESET : IDLE.
  - Unused encodings go to RESET.
- Capture: on the IDLE->SHIFT transition edge, shift_reg <= zero-extended z.
- SHIFT, each cycle: data_out <= shift_reg[0]; shift_reg <= {data_in, shift_reg[IW-1:1]}.
  - No bit count is kept. The last IW bits shifted in form the instruction.
  - data_out holds its value outside SHIFT.
- UPDATE: shadow_reg <= shift_reg.
- EXEC: decode shadow_reg; results land at the EXEC->next edge; done=1 for the following cycle only.
  - The instruction executes once. Repeated IDLE cycles never re-execute it.
- Instruction fields: op=[IW-1:IW-3], dst=[IW-4 -: REG_ADDR_W].
  - ALU ops: srcA = next REG_ADDR_W bits below dst, srcB = the lowest REG_ADDR_W bits.
  - Immediate imm=[DATA_W-1:0].
- Opcodes:
  - 000 LDI: reg[dst]=imm; z={0,imm}.
  - 001 ADD: full = A+B at DATA_W+1 bits; reg[dst]=full[DATA_W-1:0]; z=full.
  - 010 SUB: A-B mod 2**DATA_W; z MSB=1 iff A<B (borrow); reg[dst]=low bits.
  - 011 AND, 100 OR: bitwise; z MSB=0; written to dst.
  - 101 BUF: z={0,imm}; no register write.
  - 110: XOR (optional feature).
  - 111 NOP: z and registers unchanged; done still pulses.
- Operand reads use register values before this instruction's write, so dst==srcA is legal.
- zero updates whenever z updates.
- Reset mid-operation: async clear wins at any state, including partial shifts.
- x is ignored in UPDATE.

Optional Feature:
- Macro SERIAL_ALU_XOR_EN.
- Defined: opcode 110 = XOR; reg[dst]=A^B; z={0,A^B}.
- Undefined: opcode 110 behaves exactly as NOP (111).

Test Plan:
- Async reset: assert rst_n=0 during the 4th SHIFT cycle -> state RESET, z=0, data_out=0 and done=0 at once. After release with x=0, FSM reaches IDLE next cycle.
- LDI r1=5 (9'b000_01_0101) and LDI r2=12 (9'b000_10_1100), then ADD r0=r1+r2 (9'b001_00_01_10) -> z=5'h11, reg0=4'h1, zero=0. done pulses exactly once per instruction.
- SUB r3=r1-r2 (9'b010_11_01_10) -> z=5'h19 (borrow=1, diff=9), reg3=9. SUB r0=r1-r1 -> z=0, zero=1.
- AND r0=r1&r2 -> z=5'h04; OR r0=r1|r2 -> z=5'h0D. Then 20 extra IDLE cycles -> no further done pulses and z stable.
- Capture/readback: with z=5'h11, go IDLE->SHIFT and shift 9 cycles -> data_out sequence 1,0,0,0,1,0,0,0,0.
- Opcode 110 r0=r1^r2: with the macro, z=5'h09 and reg0=9. Without it, z and all registers are unchanged and done pulses.

Source files
------------

// File: rtl/serial_alu_core.sv
// Serially programmed ALU core: a 5-state FSM (mode input x) shifts in instructions LSB first,
// executes each once on a register file, and reads results back serially. XOR via SERIAL_ALU_XOR_EN.
module serial_alu_core #(
  parameter int DATA_W     = 4,
  parameter int REG_ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              x,
  input  logic              data_in,
  output logic              data_out,
  output logic [DATA_W:0]   z,
  output logic              zero,
  output logic              done
);

  localparam int NREGS = 2 ** REG_ADDR_W;
  localparam int FW    = ((DATA_W + REG_ADDR_W) > (3 * REG_ADDR_W)) ?
                         (DATA_W + REG_ADDR_W) : (3 * REG_ADDR_W);
  localparam int IW    = 3 + FW;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_EXEC   = 3'd4
  } state_t;

  state_t                  state_r, state_s;
  logic [IW-1:0]           shift_r, shadow_r;
  logic [DATA_W-1:0]       regs_r [NREGS];
  logic [DATA_W:0]         z_r;
  logic                    zero_r, data_out_r, done_r;

  logic [2:0]              op_s;
  logic [REG_ADDR_W-1:0]   dst_s, srca_s, srcb_s;
  logic [DATA_W-1:0]       imm_s, a_s, b_s;
  logic [DATA_W:0]         res_s;
  logic                    wr_en_s, z_en_s;

  assign data_out = data_out_r;
  assign z        = z_r;
  assign zero     = zero_r;
  assign done     = done_r;

  assign op_s   = shadow_r[IW-1 -: 3];
  assign dst_s  = shadow_r[IW-4 -: REG_ADDR_W];
  assign srca_s = shadow_r[IW-4-REG_ADDR_W -: REG_ADDR_W];
  assign srcb_s = shadow_r[REG_ADDR_W-1:0];
  assign imm_s  = shadow_r[DATA_W-1:0];
  assign a_s    = regs_r[srca_s];
  assign b_s    = regs_r[srcb_s];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RESET;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = ST_RESET;
    case (state_r)
      ST_RESET:  state_s = x ? ST_RESET : ST_IDLE;
      ST_IDLE:   state_s = x ? ST_SHIFT : ST_IDLE;
      ST_SHIFT:  state_s = x ? ST_SHIFT : ST_UPDATE;
      ST_UPDATE: state_s = ST_EXEC;
      ST_EXEC:   state_s = x ? ST_RESET : ST_IDLE;
      default:   state_s = ST_RESET;
    endcase
  end

  // Instruction decode and ALU; borrow falls out of the (DATA_W+1)-bit subtraction MSB
  always_comb begin
    res_s   = {(DATA_W+1){1'b0}};
    wr_en_s = 1'b0;
    z_en_s  = 1'b0;
    case (op_s)
      3'b000: begin res_s = {1'b0, imm_s};             wr_en_s = 1'b1; z_en_s = 1'b1; end
      3'b001: begin res_s = {1'b0, a_s} + {1'b0, b_s}; wr_en_s = 1'b1; z_en_s = 1'b1; end
      3'b010: begin res_s = {1'b0, a_s} - {1'b0, b_s}; wr_en_s = 1'b1; z_en_s = 1'b1; end
      3'b011: begin res_s = {1'b0, a_s & b_s};         wr_en_s = 1'b1; z_en_s = 1'b1; end
      3'b100: begin res_s = {1'b0, a_s | b_s};         wr_en_s = 1'b1; z_en_s = 1'b1; end
      3'b101: begin res_s = {1'b0, imm_s};             wr_en_s = 1'b0; z_en_s = 1'b1; end
`ifdef SERIAL_ALU_XOR_EN
      3'b110: begin res_s = {1'b0, a_s ^ b_s};         wr_en_s = 1'b1; z_en_s = 1'b1; end
`else
      3'b110: begin res_s = {(DATA_W+1){1'b0}};        wr_en_s = 1'b0; z_en_s = 1'b0; end
`endif
      default: begin res_s = {(DATA_W+1){1'b0}};       wr_en_s = 1'b0; z_en_s = 1'b0; end
    endcase
  end

  // Datapath: shift/capture, shadow load, execute and register-file write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r    <= {IW{1'b0}};
      shadow_r   <= {IW{1'b0}};
      z_r        <= {(DATA_W+1){1'b0}};
      zero_r     <= 1'b0;
      data_out_r <= 1'b0;
      done_r     <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_r[i] <= {DATA_W{1'b0}};
    end else begin
      done_r <= (state_r == ST_EXEC);
      case (state_r)
        ST_RESET: begin
          shadow_r <= {IW{1'b0}};
          z_r      <= {(DATA_W+1){1'b0}};
          zero_r   <= 1'b1;
          for (int i = 0; i < NREGS; i++) regs_r[i] <= {DATA_W{1'b0}};
        end
        ST_IDLE: begin
          if (x) shift_r <= {{(IW-DATA_W-1){1'b0}}, z_r};
        end
        ST_SHIFT: begin
          data_out_r <= shift_r[0];
          shift_r    <= {data_in, shift_r[IW-1:1]};
        end
        ST_UPDATE: begin
          shadow_r <= shift_r;
        end
        ST_EXEC: begin
          if (wr_en_s) regs_r[dst_s] <= res_s[DATA_W-1:0];
          if (z_en_s) begin
            z_r    <= res_s;
            zero_r <= (res_s[DATA_W-1:0] == {DATA_W{1'b0}});
          end
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_core.sv
// Self-checking bench for serial_alu_core: directed vector table, randomized instructions
// against a behavioural model, reset/readback corner sequences.
module tb_serial_alu_core;

  logic       clk;
  logic       rst_n;
  logic       x;
  logic       data_in;
  logic       data_out;
  logic [4:0] z;
  logic       zero;
  logic       done;

  int n_checks;
  int n_pass;

  int         mdl_regs [4];
  logic [4:0] mdl_z;
  logic       mdl_zero;

  typedef struct {
    logic [8:0] instr;
    logic [4:0] exp_z;
    logic       exp_zero;
  } vec_t;

  vec_t vecs [14];

  serial_alu_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x),
    .data_in  (data_in),
    .data_out (data_out),
    .z        (z),
    .zero     (zero),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mdl_regs[i] = 0;
    mdl_z    = 5'd0;
    mdl_zero = 1'b1;
  endtask

  task automatic model_exec(input logic [8:0] instr);
    int op, dst, a, b, imm, nz;
    bit upd;
    op  = int'(instr[8:6]);
    dst = int'(instr[5:4]);
    a   = mdl_regs[int'(instr[3:2])];
    b   = mdl_regs[int'(instr[1:0])];
    imm = int'(instr[3:0]);
    nz  = 0;
    upd = 1'b1;
    case (op)
      0: begin nz = imm; mdl_regs[dst] = imm; end
      1: begin nz = a + b; mdl_regs[dst] = nz % 16; end
      2: begin nz = (a < b) ? (a - b + 32) : (a - b); mdl_regs[dst] = nz % 16; end
      3: begin nz = a & b; mdl_regs[dst] = nz; end
      4: begin nz = a | b; mdl_regs[dst] = nz; end
      5: nz = imm;
`ifdef SERIAL_ALU_XOR_EN
      6: begin nz = a ^ b; mdl_regs[dst] = nz; end
`else
      6: upd = 1'b0;
`endif
      default: upd = 1'b0;
    endcase
    if (upd) begin
      mdl_z    = 5'(nz);
      mdl_zero = ((nz % 16) == 0);
    end
  endtask

  // Full serial transaction from IDLE back to IDLE (via RESET when exec_x=1).
  task automatic run_instr(input logic [8:0] instr, input logic exec_x,
                           output logic [4:0] zv, output logic zerov);
    int pulses;
    logic [8:0] rb;
    logic [8:0] exp_rb;
    pulses = 0;
    exp_rb = {4'b0000, mdl_z};
    x = 1'b1;
    @(negedge clk); pulses += int'(done);
    for (int i = 0; i < 9; i++) begin
      data_in = instr[i];
      x = (i < 8);
      @(negedge clk);
      rb[i] = data_out;
      pulses += int'(done);
    end
    data_in = 1'b0;
    x = 1'($urandom_range(0, 1));
    @(negedge clk); pulses += int'(done);
    x = exec_x;
    @(negedge clk);
    check("done_after_exec", int'(done), 1);
    pulses += int'(done);
    zv = z;
    zerov = zero;
    x = 1'b0;
    @(negedge clk); pulses += int'(done);
    model_exec(instr);
    check("readback", int'(rb), int'(exp_rb));
    check("done_count", pulses, 1);
    check("z_model", int'(zv), int'(mdl_z));
    check("zero_model", int'(zerov), int'(mdl_zero));
    if (exec_x) model_clear();
    for (int i = 0; i < 4; i++) check($sformatf("reg%0d", i), int'(dut.regs_r[i]), mdl_regs[i]);
  endtask

  initial begin
    logic [4:0] zv;
    logic       zerov;
    logic [4:0] z_hold;
    int         idle_pulses;
    int         z_changes;

    n_checks = 0;
    n_pass   = 0;

    vecs[0]  = '{9'b000_01_0101, 5'h05, 1'b0};
    vecs[1]  = '{9'b000_10_1100, 5'h0C, 1'b0};
    vecs[2]  = '{9'b001_00_01_10, 5'h11, 1'b0};
    vecs[3]  = '{9'b010_11_01_10, 5'h19, 1'b0};
    vecs[4]  = '{9'b010_00_01_01, 5'h00, 1'b1};
    vecs[5]  = '{9'b011_00_01_10, 5'h04, 1'b0};
    vecs[6]  = '{9'b100_00_01_10, 5'h0D, 1'b0};
`ifdef SERIAL_ALU_XOR_EN
    vecs[7]  = '{9'b110_00_01_10, 5'h09, 1'b0};
`else
    vecs[7]  = '{9'b110_00_01_10, 5'h0D, 1'b0};
`endif
    vecs[8]  = '{9'b101_00_1010, 5'h0A, 1'b0};
    vecs[9]  = '{9'b111_00_0000, 5'h0A, 1'b0};
    vecs[10] = '{9'b000_11_0000, 5'h00, 1'b1};
    vecs[11] = '{9'b000_01_1111, 5'h0F, 1'b0};
    vecs[12] = '{9'b001_00_01_01, 5'h1E, 1'b0};
    vecs[13] = '{9'b010_10_11_01, 5'h11, 1'b0};

    rst_n   = 1'b0;
    x       = 1'b0;
    data_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_z", int'(z), 0);
    check("rst_zero", int'(zero), 0);
    check("rst_done", int'(done), 0);
    check("rst_data_out", int'(data_out), 0);
    rst_n = 1'b1;
    @(negedge clk);
    model_clear();

    for (int v = 0; v < 14; v++) begin
      run_instr(vecs[v].instr, 1'b0, zv, zerov);
      check($sformatf("vec%0d_z", v), int'(zv), int'(vecs[v].exp_z));
      check($sformatf("vec%0d_zero", v), int'(zerov), int'(vecs[v].exp_zero));
    end

    idle_pulses = 0;
    z_changes   = 0;
    z_hold      = z;
    x = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      idle_pulses += int'(done);
      if (z !== z_hold) z_changes++;
    end
    check("idle_no_done", idle_pulses, 0);
    check("idle_z_stable", z_changes, 0);
    check("idle_z_value", int'(z), int'(mdl_z));

    for (int r = 0; r < 40; r++) begin
      run_instr(9'($urandom_range(0, 511)), 1'b0, zv, zerov);
    end

    run_instr(9'b000_01_0111, 1'b1, zv, zerov);
    check("exec_to_reset_z_cleared", int'(z), 0);
    run_instr(9'b000_10_0011, 1'b0, zv, zerov);

    x = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      data_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("midshift_rst_z", int'(z), 0);
    check("midshift_rst_data_out", int'(data_out), 0);
    check("midshift_rst_done", int'(done), 0);
    @(negedge clk);
    x = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    model_clear();
    run_instr(9'b101_00_0110, 1'b0, zv, zerov);
    check("post_reset_buf_z", int'(zv), 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
